// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_pkg
//  Description : Shared types and helpers for the dff_pipe register pipeline:
//                occupancy-counter width function and per-stage control struct.
//  Revision    : 1.0  initial release
// ============================================================================
package dff_pipe_pkg;

    // Width of a counter able to hold 0..n inclusive.
    function automatic int occ_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Per-stage control: stage holds a valid entry / stage may load this edge.
    typedef struct packed {
        logic vld;
        logic adv;
    } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe_stage
//  Description : One pipeline slot: a valid bit (async-reset, sync-clear) and
//                a W-bit payload register, both updated on a shared load enable.
//  Revision    : 1.0  initial release
// ============================================================================
module dff_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic         i_vld,
    input  logic [W-1:0] i_d,
    output logic         o_vld,
    output logic [W-1:0] o_q
);

    logic         r_vld;
    logic [W-1:0] r_dat;

    // Valid bit: cleared by reset or flush, otherwise follows the source on load.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_vld <= 1'b0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (i_ld) begin
            r_vld <= i_vld;
        end
    end

    // Payload carries no reset; its value is only meaningful while r_vld is set.
    always_ff @(posedge clk) begin
        if (i_ld) begin
            r_dat <= i_d;
        end
    end

    assign o_vld = r_vld;
    assign o_q   = r_dat;

endmodule
`default_nettype wire

// File: rtl/dff_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pipe
//  Description : N-stage, W-bit register pipeline with per-stage valid bits,
//                valid/ready flow control, bubble collapsing and sync flush.
//                Optional feature macro: DFF_PIPE_OCC_EN adds the registered
//                occupancy output occ and its consistency check.
//  Revision    : 1.0  initial release
// ============================================================================
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int W = 1,
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flush,
    input  logic                  in_vld,
    input  logic [W-1:0]          in_d,
    output logic                  in_rdy,
    output logic                  out_vld,
    output logic [W-1:0]          out_q,
`ifdef DFF_PIPE_OCC_EN
    output logic [occ_w(N)-1:0]   occ,
`endif
    input  logic                  out_rdy
);

    stage_ctl_t   w_ctl [N];
    logic [N-1:0] w_vld;
    logic [W-1:0] w_q   [N];

    // Advance chain: a stage may load when the stage after it moves or when it
    // is empty, so bubbles are filled even while the output is stalled.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_ctl[i].vld = w_vld[i];
            w_ctl[i].adv = 1'b0;
        end
        w_ctl[N-1].adv = out_rdy | ~w_ctl[N-1].vld;
        for (int i = N - 2; i >= 0; i--) begin
            w_ctl[i].adv = w_ctl[i+1].adv | ~w_ctl[i].vld;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stage
        logic         w_src_vld;
        logic [W-1:0] w_src_d;

        if (g == 0) begin : g_head
            assign w_src_vld = in_vld;
            assign w_src_d   = in_d;
        end else begin : g_body
            assign w_src_vld = w_vld[g-1];
            assign w_src_d   = w_q[g-1];
        end

        dff_pipe_stage #(
            .W (W)
        ) u_stage (
            .clk    (clk),
            .arst_n (arst_n),
            .i_clr  (flush),
            .i_ld   (w_ctl[g].adv),
            .i_vld  (w_src_vld),
            .i_d    (w_src_d),
            .o_vld  (w_vld[g]),
            .o_q    (w_q[g])
        );
    end

    assign in_rdy  = w_ctl[0].adv & ~flush;
    assign out_vld = w_vld[N-1];
    assign out_q   = w_q[N-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int c_OCC_W = occ_w(N);

    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_OCC_W-1:0] r_occ;

    assign w_in_xfer  = in_vld & in_rdy;
    assign w_out_xfer = out_vld & out_rdy;

    // Occupancy: +1 per accepted entry, -1 per delivered entry, flush empties.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occ = r_occ;

    // The counter must always agree with the number of valid stages.
    a_occ_matches_vld: assert property (@(posedge clk) disable iff (!arst_n)
        r_occ == c_OCC_W'($countones(w_vld)));
`endif

endmodule
`default_nettype wire

// File: doc/dff_pipe.md
# dff_pipe

- Parametrised successor to the single-stage flop: an N-stage, W-bit register pipeline with a per-stage valid bit, valid/ready flow control and bubble collapsing.
- Used wherever a datapath needs retiming depth under backpressure, without a full FIFO.
- Any stage holding a bubble accepts new data even while the output is stalled.
- A synchronous flush drops all in-flight entries.

## Interface
Parameters:
- W, 1, payload width in bits (W ≥ 1)
- N, 2, number of register stages (N ≥ 1)

Ports:
- clk  in  1  clock; all state updates on posedge clk
- arst_n  in  1  reset; asynchronous assert, active-low
- flush  in  1  synchronous flush; invalidates all stages at next edge
- in_vld  in  1  input entry valid
- in_d  in  W  input payload
- in_rdy  out  1  pipeline can accept input this cycle
- out_vld  out  1  stage N-1 holds a valid entry
- out_q  out  W  stage N-1 payload
- out_rdy  in  1  downstream accepts output this cycle
- occ  out  $clog2(N+1)  count of valid stages; present only with DFF_PIPE_OCC_EN

## Operation
- State:
  - vld[0..N-1] is reset by arst_n to 0.
  - dat[0..N-1] has no reset and is captured only on advance.
- Stage advance:
  - adv[N-1] = out_rdy | !vld[N-1]
  - adv[i] = adv[i+1] | !vld[i], for i < N-1
  - On adv[i], stage i loads from stage i-1; stage 0 loads from in_vld/in_d.
  - A stage with !adv[i] holds its contents.
- in_rdy = adv[0] & !flush. An input transfer occurs when in_vld & in_rdy.
- An output transfer occurs when out_vld & out_rdy.
- Bubble collapse: a bubble at stage i is filled from stage i-1 regardless of out_rdy.
- Flush:
  - At the next edge all vld bits are 0, and the occ counter (when compiled in) is cleared.
  - The output transfer in the flush cycle still completes if out_vld & out_rdy.
  - No input is accepted in the flush cycle.
- dat of an invalid stage is don't-care. out_q is meaningful only when out_vld = 1.
- Ordering: entries leave strictly in acceptance order. No entry is duplicated or lost except by flush.

## Timing
- Reset values: out_vld = 0, occ = 0, in_rdy = !flush.
- out_q is undefined until the first valid entry reaches stage N-1.
- Latency: an entry accepted in cycle t presents out_vld = 1 in cycle t+N with no stalls.
- Throughput: 1 entry/cycle when out_rdy is held high.
- in_rdy depends combinationally on out_rdy and on all vld bits. There is no combinational path from in_vld or in_d to any output.
- Full pipeline (all vld = 1) with out_rdy = 0: in_rdy = 0 and all stages hold.
- Full pipeline with out_rdy = 1: simultaneous input and output in the same cycle, and occ is unchanged.
- arst_n asserted mid-operation: all vld clear immediately (async), and all in-flight entries are lost. Operation resumes at the first clk edge after deassertion.

## Configuration
- DFF_PIPE_OCC_EN defined:
  - Port occ is present, driven by a registered counter.
  - Each edge: +1 on input transfer, −1 on output transfer, both ⇒ unchanged.
  - Flush forces occ to 0.
  - The counter range is 0..N. An internal check fires if occ ≠ popcount(vld).
- DFF_PIPE_OCC_EN undefined: the occ port and counter are absent. Flow-control behaviour is otherwise identical.

## Structure
- Package dff_pipe_pkg holds:
  - the occ width function occ_w(N) = $clog2(N+1)
  - a typedef for the stage control struct {vld, adv}
- Sub-module dff_pipe_stage: one valid bit plus W-bit data register with a load enable.
  - It is instantiated N times in a generate loop.
  - The top computes the adv chain and the occ logic.

## Test plan
- Stream: W=8, N=3, out_rdy = 1; drive 0x01..0x10 back-to-back → out_vld first high in cycle 3, values 0x01..0x10 in order, in_rdy constantly 1.
- Backpressure fill: N=3, out_rdy = 0; push 0xA0, 0xA1, 0xA2 → in_rdy = 0 after the third accept; occ = 3. Raise out_rdy → output 0xA0, 0xA1, 0xA2 in order and in_rdy = 1 in the same cycle.
- Bubble collapse: N=4, one entry 0x55 stalled at the output with out_rdy = 0 → three further entries accepted, then in_rdy = 0; occ = 4.
- Flush: pipeline holding 3 entries, out_rdy = 1, flush for one cycle → the head entry exits that cycle and in_rdy = 0. Next cycle out_vld = 0, occ = 0, and a new entry 0x77 appears N cycles after acceptance.
- Async reset: drop arst_n between clock edges with 2 entries in flight → out_vld = 0 and occ = 0 immediately. Release arst_n → in_rdy = 1 and normal streaming resumes.
- N=1 corner: out_rdy toggling every cycle with in_vld = 1 → exactly one transfer per out_rdy-high cycle and no entry dropped.
